// File: rtl/apb2ahb_pkg.sv
// Shared types and AHB encodings for the APB-to-AHB bridge.
package apb2ahb_pkg;

  // FSM encoding, exported on the debug port as well.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Data/opcode from PPROT[0] (privileged), bufferable unused, data when PPROT[2]=0.
  function automatic logic [3:0] hprot_from_pprot(input logic [2:0] pprot);
    return {2'b00, pprot[0], ~pprot[2]};
  endfunction

endpackage

// File: rtl/apb2ahb_bridge_if.sv
// Bus bundles for the bridge: APB (bridge is the completer) and AHB-Lite
// (bridge is the master).
//
// Handshakes: an APB access is one setup cycle (PSEL=1, PENABLE=0) then access
// cycles (PSEL=1, PENABLE=1) until PREADY=1; every APB-side edge counts only
// when PCLKEN=1. On AHB, an address phase with HTRANS=NONSEQ is accepted on the
// edge where HREADY=1; the data phase ends on the next edge where HREADY=1, and
// HRESP qualifies that completion.
interface apb2ahb_apb_if #(parameter int ADDRWIDTH = 14);
  logic                 PCLKEN;
  logic                 PSEL;
  logic                 PENABLE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic                 PWRITE;
  logic [31:0]          PWDATA;
  logic [3:0]           PSTRB;
  logic [2:0]           PPROT;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PCLKEN, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

interface apb2ahb_ahb_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HMASTLOCK;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HWDATA, HMASTLOCK,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HWDATA, HMASTLOCK,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/apb2ahb_strb_dec.sv
// Maps APB byte strobes onto a single AHB transfer size and low address bits.
module apb2ahb_strb_dec
  import apb2ahb_pkg::*;
(
  input  logic       pwrite,
  input  logic [3:0] pstrb,
  output logic [2:0] hsize,
  output logic [1:0] addr_lo,
  output logic       nop,
  output logic       illegal
);

  // Reads are always full words; writes need a naturally aligned strobe pattern.
  always_comb begin
    hsize   = HSIZE_WORD;
    addr_lo = 2'b00;
    nop     = 1'b0;
    illegal = 1'b0;
    if (pwrite) begin
      case (pstrb)
        4'b1111: begin hsize = HSIZE_WORD; addr_lo = 2'b00; end
        4'b0011: begin hsize = HSIZE_HALF; addr_lo = 2'b00; end
        4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
        4'b0001: begin hsize = HSIZE_BYTE; addr_lo = 2'b00; end
        4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
        4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
        4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
        4'b0000: nop = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/apb2ahb_bridge.sv
// APB completer that turns each APB access into one single AHB-Lite transfer.
// One transfer in flight at a time; the APB access phase is stretched until
// the AHB data phase has finished.
module apb2ahb_bridge
  import apb2ahb_pkg::*;
#(
  parameter int          ADDRWIDTH = 14,
  parameter logic [31:0] AHB_BASE  = 32'h4000_0000
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  apb2ahb_apb_if.slave   apb,
  apb2ahb_ahb_if.master  ahb,
  output logic           BUSY,
  output state_t         dbg_state
);

  state_t      state_q, state_d;
  logic        capture;
  logic        apb_setup, apb_access;

  logic [2:0]  dec_hsize;
  logic [1:0]  dec_addr_lo;
  logic        dec_nop, dec_illegal;

  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [3:0]  hprot_q;
  logic [31:0] hwdata_q;
  logic        err_q;
  logic [31:0] prdata_q;

  // Word-aligned PADDR bits are replaced by the strobe decode; PPROT[1] has no AHB equivalent.
  logic        unused_bits;
  assign unused_bits = ^{apb.PADDR[1:0], apb.PPROT[1]};

  assign apb_setup  = apb.PCLKEN & apb.PSEL & ~apb.PENABLE;
  assign apb_access = apb.PCLKEN & apb.PSEL &  apb.PENABLE;

  apb2ahb_strb_dec u_strb_dec (
    .pwrite  (apb.PWRITE),
    .pstrb   (apb.PSTRB),
    .hsize   (dec_hsize),
    .addr_lo (dec_addr_lo),
    .nop     (dec_nop),
    .illegal (dec_illegal)
  );

  // State register; reset abandons any partially issued AHB transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: NOP and illegal strobes skip the AHB side and answer directly.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (apb_setup) begin
          capture = 1'b1;
          state_d = (dec_nop || dec_illegal) ? ST_RESP : ST_ADDR;
        end
      end
      ST_ADDR: if (ahb.HREADY) state_d = ST_DATA;
      ST_DATA: if (ahb.HREADY) state_d = ST_RESP;
      ST_RESP: if (apb_access) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer attributes latched at APB setup, completion status at AHB data end.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hprot_q  <= '0;
      hwdata_q <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else if (capture) begin
      haddr_q  <= {AHB_BASE[31:ADDRWIDTH], apb.PADDR[ADDRWIDTH-1:2], dec_addr_lo};
      hwrite_q <= apb.PWRITE;
      hsize_q  <= dec_hsize;
      hprot_q  <= hprot_from_pprot(apb.PPROT);
      hwdata_q <= apb.PWDATA;
      err_q    <= dec_illegal;
    end else if (state_q == ST_DATA && ahb.HREADY) begin
      err_q <= ahb.HRESP;
      if (ahb.HRESP)      prdata_q <= '0;
      else if (!hwrite_q) prdata_q <= ahb.HRDATA;
    end
  end

  assign ahb.HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.HADDR     = haddr_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HSIZE     = hsize_q;
  assign ahb.HPROT     = hprot_q;
  assign ahb.HWDATA    = hwdata_q;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HMASTLOCK = 1'b0;

  assign apb.PREADY  = (state_q == ST_RESP) & apb_access;
  assign apb.PSLVERR = apb.PREADY & err_q;
  assign apb.PRDATA  = prdata_q;

  assign BUSY      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Directed bench for apb2ahb_bridge: APB master tasks, a reactive AHB slave
// with programmable wait states/errors, and hand-computed expected values.
module tb_apb2ahb_bridge;
  import apb2ahb_pkg::*;

  localparam int AW = 14;

  logic   HCLK    = 1'b0;
  logic   HRESETn = 1'b1;
  logic   BUSY;
  state_t dbg_state;

  apb2ahb_apb_if #(.ADDRWIDTH(AW)) apb();
  apb2ahb_ahb_if                   ahb();

  apb2ahb_bridge #(.ADDRWIDTH(AW), .AHB_BASE(32'h4000_0000)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .apb       (apb),
    .ahb       (ahb),
    .BUSY      (BUSY),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // AHB slave model
  int          slv_waits = 0;
  bit          slv_err   = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          nonseq_cnt = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [2:0]  seen_size;
  logic        seen_write;
  logic [3:0]  seen_prot;
  bit          dp;
  int          wcnt;

  initial begin
    ahb.HREADY = 1'b1;
    ahb.HRESP  = 1'b0;
    ahb.HRDATA = '0;
    dp = 1'b0;
    wcnt = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp = 1'b0;
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
      end else if (dp) begin
        seen_wdata = ahb.HWDATA;
        if (wcnt < slv_waits) begin
          ahb.HREADY = 1'b0;
          ahb.HRESP  = slv_err && (wcnt == slv_waits - 1);
          wcnt++;
        end else begin
          ahb.HREADY = 1'b1;
          ahb.HRESP  = slv_err;
          ahb.HRDATA = slv_rdata;
          dp = 1'b0;
        end
      end else begin
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
        if (ahb.HTRANS == HTRANS_NONSEQ) begin
          nonseq_cnt++;
          seen_addr  = ahb.HADDR;
          seen_size  = ahb.HSIZE;
          seen_write = ahb.HWRITE;
          seen_prot  = ahb.HPROT;
          dp   = 1'b1;
          wcnt = 0;
        end
      end
    end
  end

  // PCLKEN: constant 1, or toggling every cycle
  bit pclk_toggle = 1'b0;
  initial begin
    apb.PCLKEN = 1'b1;
    forever begin
      @(posedge HCLK);
      #1 apb.PCLKEN = pclk_toggle ? ~apb.PCLKEN : 1'b1;
    end
  end

  // APB master driver
  bit apb_abort = 1'b0;

  task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rdata, output logic err, output int waits);
    bit en;
    bit done;
    int n;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = addr; apb.PWRITE = wr;
    apb.PWDATA = wdata; apb.PSTRB = strb; apb.PPROT = prot;
    n = 0;
    do begin
      @(negedge HCLK);
      en = apb.PCLKEN;
      @(posedge HCLK);
      n++;
    end while (!en && n < 20);
    #1 apb.PENABLE = 1'b1;
    waits = 0; done = 1'b0; rdata = 'x; err = 1'bx;
    for (int i = 0; i < 60 && !done && !apb_abort; i++) begin
      @(negedge HCLK);
      if (!apb_abort) begin
        if (apb.PCLKEN && apb.PREADY) begin
          done  = 1'b1;
          rdata = apb.PRDATA;
          err   = apb.PSLVERR;
        end else begin
          waits++;
        end
      end
    end
    if (!apb_abort) check("apb_done", done, 1);
    @(posedge HCLK);
    #1 apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  // Main sequence
  logic [31:0] rd;
  logic        er;
  int          w;
  int          n0;

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = '0; apb.PWRITE = 1'b0;
    apb.PWDATA = '0; apb.PSTRB = '0; apb.PPROT = '0;
    #1 HRESETn = 1'b0;
    #11;
    check("rst_htrans",  ahb.HTRANS, 2'b00);
    check("rst_haddr",   ahb.HADDR, 32'h0);
    check("rst_pready",  apb.PREADY, 1'b0);
    check("rst_busy",    BUSY, 1'b0);
    check("rst_burst",   ahb.HBURST, 3'b000);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Word write, zero-wait slave
    n0 = nonseq_cnt;
    apb_xfer(14'h0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, rd, er, w);
    check("ww_haddr",  seen_addr, 32'h4000_0010);
    check("ww_hsize",  seen_size, 3'd2);
    check("ww_hwrite", seen_write, 1'b1);
    check("ww_hwdata", seen_wdata, 32'hDEAD_BEEF);
    check("ww_hprot",  seen_prot, 4'b0011);
    check("ww_err",    er, 1'b0);
    check("ww_waits",  w, 2);
    check("ww_nonseq", nonseq_cnt - n0, 1);

    // Byte write to lane 2
    apb_xfer(14'h0040, 1'b1, 32'h00AA_0000, 4'b0100, 3'b000, rd, er, w);
    check("bw_haddr", seen_addr, 32'h4000_0042);
    check("bw_hsize", seen_size, 3'd0);
    check("bw_hprot", seen_prot, 4'b0001);

    // Upper half write
    apb_xfer(14'h0044, 1'b1, 32'hBBBB_0000, 4'b1100, 3'b100, rd, er, w);
    check("hw_haddr", seen_addr, 32'h4000_0046);
    check("hw_hsize", seen_size, 3'd1);
    check("hw_hprot", seen_prot, 4'b0000);

    // Read with 3 wait states (strobes ignored on reads)
    slv_waits = 3; slv_rdata = 32'h1234_5678;
    apb_xfer(14'h0020, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("rd_prdata", rd, 32'h1234_5678);
    check("rd_err",    er, 1'b0);
    check("rd_waits",  w, 5);
    check("rd_haddr",  seen_addr, 32'h4000_0020);
    check("rd_hsize",  seen_size, 3'd2);
    check("rd_hwrite", seen_write, 1'b0);
    slv_waits = 0;

    // NOP write: no AHB transfer, OKAY, PRDATA keeps the last read
    n0 = nonseq_cnt;
    apb_xfer(14'h0028, 1'b1, 32'h1111_1111, 4'b0000, 3'b000, rd, er, w);
    check("nop_err",    er, 1'b0);
    check("nop_waits",  w, 0);
    check("nop_nonseq", nonseq_cnt - n0, 0);
    check("nop_prdata_hold", rd, 32'h1234_5678);

    // Illegal strobe: no AHB transfer, error
    n0 = nonseq_cnt;
    apb_xfer(14'h0028, 1'b1, 32'h2222_2222, 4'b0110, 3'b000, rd, er, w);
    check("ill_err",    er, 1'b1);
    check("ill_waits",  w, 0);
    check("ill_nonseq", nonseq_cnt - n0, 0);

    // Two-cycle AHB ERROR on a read
    slv_waits = 1; slv_err = 1'b1; slv_rdata = 32'hFFFF_FFFF;
    apb_xfer(14'h0024, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("er_err",    er, 1'b1);
    check("er_prdata", rd, 32'h0);
    check("er_waits",  w, 3);
    slv_waits = 0; slv_err = 1'b0;

    // Zero-wait read to leave PRDATA non-zero
    slv_rdata = 32'hA5A5_0F0F;
    apb_xfer(14'h002C, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("rd2_prdata", rd, 32'hA5A5_0F0F);
    check("rd2_waits",  w, 2);

    // Reset during the data phase with PCLKEN toggling
    pclk_toggle = 1'b1;
    slv_waits = 10;
    apb_abort = 1'b0;
    fork
      apb_xfer(14'h0030, 1'b0, 32'h5555_AAAA, 4'h0, 3'b000, rd, er, w);
      begin
        int k;
        k = 0;
        while (dbg_state != ST_DATA && k < 40) begin
          @(negedge HCLK);
          k++;
        end
        check("mr_reach_data", dbg_state == ST_DATA, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        check("mr_htrans", ahb.HTRANS, 2'b00);
        check("mr_haddr",  ahb.HADDR, 32'h0);
        check("mr_hwdata", ahb.HWDATA, 32'h0);
        check("mr_hsize",  ahb.HSIZE, 3'd0);
        check("mr_prdata", apb.PRDATA, 32'h0);
        check("mr_pready", apb.PREADY, 1'b0);
        check("mr_pslverr", apb.PSLVERR, 1'b0);
        check("mr_busy",   BUSY, 1'b0);
        apb_abort = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
      end
    join
    apb_abort = 1'b0;
    slv_waits = 0;
    slv_rdata = 32'hCAFE_F00D;
    @(posedge HCLK); #1;
    apb_xfer(14'h0030, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, w);
    check("ar_prdata", rd, 32'hCAFE_F00D);
    check("ar_err",    er, 1'b0);
    check("ar_haddr",  seen_addr, 32'h4000_0030);
    pclk_toggle = 1'b0;

    repeat (3) @(posedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    bad++;
    $display("FAIL global_timeout: got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
